dr32e_branch_predict_dyn: RTL
=============================

Name: dr32e_branch_predict_dyn

Overview:
- Dynamic branch predictor for the dr32e fetch stage; next generation of the static predictor.
- Decodes RV32 and compressed branches and jumps from the fetch word and computes targets combinationally.
- Direction for conditional branches comes from a parametrised table of saturating counters, trained by resolved-branch updates from the execute stage.
- Untrained entries fall back to the static rule: taken if the offset is negative.

Parameters:
- BHT_ENTRIES, 64, number of counter entries; power of two, >= 2.
- CNT_W, 2, saturating counter width; 2..4.
- GHR_W, 6, global history length; used only with the optional feature; GHR_W <= IDX_W.
- Derived: IDX_W = $clog2(BHT_ENTRIES).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- fetch_rdata_i  in  32  fetched instruction; compressed instruction in bits [15:0].
- fetch_pc_i  in  32  PC of the fetched instruction.
- fetch_valid_i  in  1  fetch word valid.
- predict_branch_taken_o  out  1  predict taken.
- predict_branch_pc_o  out  32  predicted target, fetch_pc_i + imm.
- predict_idx_o  out  IDX_W  table index used for this prediction; carried down the pipeline.
- ex_valid_i  in  1  a conditional branch resolved this cycle.
- ex_idx_i  in  IDX_W  predict_idx_o value carried back with the resolved branch.
- ex_taken_i  in  1  resolved direction.
- ex_mispredict_i  in  1  resolved direction differed from the prediction; statistics only.
- mispredict_cnt_o  out  32  saturating mispredict count.

Behaviour:
- Decode:
  - J, B, CJ, CB detection and immediates use standard RV32C encodings.
  - At most one of the four is set; if none, the target uses imm_b.
  - Target is computed modulo 2^32.
- Index: idx = fetch_pc_i[IDX_W:1]. Bit 0 is ignored because fetch is 2-byte aligned.
- State per entry: cnt[CNT_W-1:0] and valid bit v.
- Reset (async, rst_ni low):
  - all cnt = 2^(CNT_W-1)-1 (weakly not-taken), all v = 0;
  - mispredict_cnt_o = 0;
  - predict_branch_taken_o = 0 because fetch_valid_i is low; outputs are otherwise combinational.
- Prediction (combinational, zero latency):
  - J or CJ: taken = fetch_valid_i.
  - B or CB, v[idx] = 1: taken = fetch_valid_i & cnt[idx][CNT_W-1].
  - B or CB, v[idx] = 0: taken = fetch_valid_i & imm sign bit.
  - Other instructions: taken = 0.
- Update, registered, visible to lookups from the next cycle:
  - If ex_valid_i: v[ex_idx_i] <= 1.
  - cnt[ex_idx_i] increments when ex_taken_i, decrements otherwise; saturates at 0 and 2^CNT_W-1.
  - First update of an invalid entry: cnt <= ex_taken_i ? 2^(CNT_W-1) : 2^(CNT_W-1)-1 (weak in the resolved direction). No increment is applied.
- Simultaneous lookup and update on the same index: the lookup sees the pre-update value. No bypass.
- Mispredict counter: increments when ex_valid_i & ex_mispredict_i; holds at 32'hFFFF_FFFF.
- ex_valid_i low: no state change.
- Reset mid-update: reset wins and the update is lost.

Optional Feature:
- Macro: DR32E_BP_GSHARE_EN.
- With the macro:
  - An internal GHR_W-bit register ghr, reset to 0.
  - idx = fetch_pc_i[IDX_W:1] ^ {{(IDX_W-GHR_W){1'b0}}, ghr}.
  - On ex_valid_i: ghr <= {ghr[GHR_W-2:0], ex_taken_i}. History is non-speculative.
  - Because the pipeline returns the lookup index, the update indexes the same entry the prediction used.
- Without the macro: no ghr flops; idx is PC bits only. GHR_W is ignored.

Decomposition:
- Add to dr32e_pkg:
  - bp_cnt_init function, returning the weak counter value for a direction;
  - bp_instr_type_e enum {BP_NONE, BP_J, BP_B, BP_CJ, BP_CB}.
- One sub-module, dr32e_bp_decode: purely combinational type decode, immediate select and target add.
- The counter table and update logic stay in the top module.

Test Plan:
- Reset then fetch BEQ with offset -8 at pc 0x100, fetch_valid_i = 1 -> taken = 1, target = 0xF8, predict_idx_o = 0 (0x100[6:1] with default parameters).
- Same BEQ, issue ex_valid_i with ex_taken_i = 0 twice at that index -> entry becomes valid with cnt = 01, then 00 -> prediction = 0 despite the negative offset.
- Three taken updates on one index -> cnt = 11. A fourth taken update holds at 11. Two not-taken updates -> 01 and prediction = 0.
- C.J at pc 0x200 with offset +0x20 -> taken = 1, target = 0x220. Same word with fetch_valid_i = 0 -> taken = 0, target still 0x220.
- Update and lookup of index 5 in the same cycle, entry starting valid with cnt = 01, update taken -> that cycle predicts 0, the next cycle predicts 1 (cnt = 10).
- DR32E_BP_GSHARE_EN, pc 0x100:
  - after outcomes T, T, N (IDX_W = 6, GHR_W = 6) -> ghr = 0b000110 and predict_idx_o = 0x00 ^ 0x06 = 0x06;
  - assert rst_ni low mid-run -> ghr = 0, all v = 0, mispredict_cnt_o = 0.

Source files
------------

// File: rtl/dr32e_pkg.sv
// Shared dr32e types and helpers used by the branch predictor.
// Pure declarations; no logic and no latency.
// No flow control.
package dr32e_pkg;

    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    typedef enum logic [2:0] {
        BP_NONE,
        BP_J,
        BP_B,
        BP_CJ,
        BP_CB
    } bp_instr_type_e;

    // Weak counter value in the given direction: 10..0 for taken, 01..1 for not-taken.
    function automatic logic [3:0] bp_cnt_init(input int unsigned cnt_w, input logic taken);
        logic [3:0] half;
        half = 4'(1 << (cnt_w - 1));
        return taken ? half : half - 4'd1;
    endfunction

endpackage

// File: rtl/dr32e_branch_predict_dyn_if.sv
// Fetch lookup, prediction result and execute-stage training bundle.
// Master drives fetch/execute inputs; slave is the predictor.
// No flow control: every field is sampled or produced each cycle.
interface dr32e_branch_predict_dyn_if #(
    parameter int unsigned IDX_W = 6
);
    logic [31:0]      fetch_rdata_i;
    logic [31:0]      fetch_pc_i;
    logic             fetch_valid_i;
    logic             predict_branch_taken_o;
    logic [31:0]      predict_branch_pc_o;
    logic [IDX_W-1:0] predict_idx_o;
    logic             ex_valid_i;
    logic [IDX_W-1:0] ex_idx_i;
    logic             ex_taken_i;
    logic             ex_mispredict_i;
    logic [31:0]      mispredict_cnt_o;

    modport master (
        output fetch_rdata_i, fetch_pc_i, fetch_valid_i,
        output ex_valid_i, ex_idx_i, ex_taken_i, ex_mispredict_i,
        input  predict_branch_taken_o, predict_branch_pc_o, predict_idx_o, mispredict_cnt_o
    );

    modport slave (
        input  fetch_rdata_i, fetch_pc_i, fetch_valid_i,
        input  ex_valid_i, ex_idx_i, ex_taken_i, ex_mispredict_i,
        output predict_branch_taken_o, predict_branch_pc_o, predict_idx_o, mispredict_cnt_o
    );
endinterface

// File: rtl/dr32e_bp_decode.sv
// Classifies the fetch word as J/B/CJ/CB and forms the branch target.
// Purely combinational, zero latency.
// No flow control.
module dr32e_bp_decode
    import dr32e_pkg::*;
(
    input  logic [31:0]    instr_i,
    input  logic [31:0]    pc_i,
    output bp_instr_type_e type_o,
    output logic           imm_sign_o,
    output logic [31:0]    target_o
);
    logic [31:0] imm_j, imm_b, imm_cj, imm_cb, imm;

    always_comb begin
        imm_j  = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        imm_b  = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        imm_cj = {{20{instr_i[12]}}, instr_i[12], instr_i[8], instr_i[10:9], instr_i[6],
                  instr_i[7], instr_i[2], instr_i[11], instr_i[5:3], 1'b0};
        imm_cb = {{23{instr_i[12]}}, instr_i[12], instr_i[6:5], instr_i[2],
                  instr_i[11:10], instr_i[4:3], 1'b0};

        type_o = BP_NONE;
        imm    = imm_b;
        if (instr_i[6:0] == OPC_JAL) begin
            type_o = BP_J;
            imm    = imm_j;
        end else if (instr_i[6:0] == OPC_BRANCH) begin
            type_o = BP_B;
            imm    = imm_b;
        end else if (instr_i[1:0] == 2'b01 &&
                     (instr_i[15:13] == 3'b101 || instr_i[15:13] == 3'b001)) begin
            // C.J and the RV32-only C.JAL share the CJ immediate layout.
            type_o = BP_CJ;
            imm    = imm_cj;
        end else if (instr_i[1:0] == 2'b01 && instr_i[15:14] == 2'b11) begin
            type_o = BP_CB;
            imm    = imm_cb;
        end

        imm_sign_o = imm[31];
        target_o   = pc_i + imm;
    end
endmodule

// File: rtl/dr32e_branch_predict_dyn.sv
// Dynamic branch predictor: saturating-counter BHT with static fallback; optional gshare (DR32E_BP_GSHARE_EN).
// Prediction is combinational (zero latency); training is registered and visible next cycle.
// No backpressure: one lookup and at most one update are accepted every cycle.
module dr32e_branch_predict_dyn
    import dr32e_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned GHR_W       = 6
) (
    input logic clk_i,
    input logic rst_ni,
    dr32e_branch_predict_dyn_if.slave bp
);
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(bp_cnt_init(CNT_W, 1'b1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(bp_cnt_init(CNT_W, 1'b0));

    if (GHR_W < 2 || GHR_W > IDX_W || CNT_W < 2 || CNT_W > 4) begin : g_param_check
        $error("dr32e_branch_predict_dyn: illegal CNT_W/GHR_W");
    end

    logic [CNT_W-1:0] cnt_q [BHT_ENTRIES];
    logic [CNT_W-1:0] cnt_d [BHT_ENTRIES];
    logic [BHT_ENTRIES-1:0] v_q, v_d;
    logic [31:0]      mis_cnt_q, mis_cnt_d;
    logic [IDX_W-1:0] idx;
    bp_instr_type_e   dec_type;
    logic             dec_sign;

    dr32e_bp_decode u_decode (
        .instr_i    (bp.fetch_rdata_i),
        .pc_i       (bp.fetch_pc_i),
        .type_o     (dec_type),
        .imm_sign_o (dec_sign),
        .target_o   (bp.predict_branch_pc_o)
    );

`ifdef DR32E_BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (bp.ex_valid_i) ghr_d = {ghr_q[GHR_W-2:0], bp.ex_taken_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ghr_q <= '0;
        else         ghr_q <= ghr_d;
    end

    assign idx = bp.fetch_pc_i[IDX_W:1] ^ IDX_W'(ghr_q);
`else
    assign idx = bp.fetch_pc_i[IDX_W:1];
`endif

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        bp.predict_branch_taken_o = 1'b0;
        case (dec_type)
            BP_J, BP_CJ: bp.predict_branch_taken_o = bp.fetch_valid_i;
            BP_B, BP_CB: bp.predict_branch_taken_o = bp.fetch_valid_i &
                                                     (v_q[idx] ? cnt_q[idx][CNT_W-1] : dec_sign);
            default:     bp.predict_branch_taken_o = 1'b0;
        endcase
    end

    assign bp.predict_idx_o    = idx;
    assign bp.mispredict_cnt_o = mis_cnt_q;

    always_comb begin
        cnt_d     = cnt_q;
        v_d       = v_q;
        mis_cnt_d = mis_cnt_q;
        if (bp.ex_valid_i) begin
            v_d[bp.ex_idx_i] = 1'b1;
            if (!v_q[bp.ex_idx_i]) begin
                cnt_d[bp.ex_idx_i] = bp.ex_taken_i ? CNT_WT : CNT_WNT;
            end else if (bp.ex_taken_i) begin
                if (cnt_q[bp.ex_idx_i] != CNT_MAX) cnt_d[bp.ex_idx_i] = cnt_q[bp.ex_idx_i] + 1'b1;
            end else begin
                if (cnt_q[bp.ex_idx_i] != '0) cnt_d[bp.ex_idx_i] = cnt_q[bp.ex_idx_i] - 1'b1;
            end
            if (bp.ex_mispredict_i && mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) cnt_q[i] <= CNT_WNT;
            v_q       <= '0;
            mis_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            v_q       <= v_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end
endmodule
